// File: rtl/tilelink_ul_arbiter_if.sv
// rtl/tilelink_ul_arbiter_if.sv - TL-UL A/D channel bundle, N-wide on the requester side, 1-wide downstream
interface tilelink_ul_arbiter_if #(
    parameter int N     = 1,
    parameter int SRC_W = 1
);
    logic [N-1:0]            a_valid;
    logic [N-1:0]            a_ready;
    logic [N-1:0][2:0]       a_bits_opcode;
    logic [N-1:0][2:0]       a_bits_param;
    logic [N-1:0][3:0]       a_bits_size;
    logic [N-1:0][SRC_W-1:0] a_bits_source;
    logic [N-1:0][31:0]      a_bits_address;
    logic [N-1:0][3:0]       a_bits_mask;
    logic [N-1:0][31:0]      a_bits_data;

    logic [N-1:0]            d_valid;
    logic [N-1:0]            d_ready;
    // D fields are shared by every lane; only the lane whose d_valid is set owns them
    logic [2:0]              d_bits_opcode;
    logic [1:0]              d_bits_param;
    logic [3:0]              d_bits_size;
    logic [SRC_W-1:0]        d_bits_source;
    logic                    d_bits_sink;
    logic [1:0]              d_bits_addr_lo;
    logic [31:0]             d_bits_data;
    logic                    d_bits_error;

    modport master (
        output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
               a_bits_address, a_bits_mask, a_bits_data, d_ready,
        input  a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size,
               d_bits_source, d_bits_sink, d_bits_addr_lo, d_bits_data, d_bits_error
    );

    modport slave (
        input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
               a_bits_address, a_bits_mask, a_bits_data, d_ready,
        output a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size,
               d_bits_source, d_bits_sink, d_bits_addr_lo, d_bits_data, d_bits_error
    );
endinterface

// File: rtl/tilelink_ul_arbiter.sv
// rtl/tilelink_ul_arbiter.sv - round-robin TL-UL arbiter, one transaction outstanding, owner holds the slave A-first to D-last
module tilelink_ul_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int SRC_W       = 1,
    parameter int MAX_SIZE    = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    tilelink_ul_arbiter_if.slave   m,
    tilelink_ul_arbiter_if.master  s,
    output logic                   busy
);
    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = MAX_SIZE - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        A_XFER = 2'd2,
        D_WAIT = 2'd3
    } state_t;

    state_t         state;
    logic [PW-1:0]  owner;
    logic [PW-1:0]  rr_ptr;
    logic [CW-1:0]  count;
    logic [3:0]     req_size;
    logic [2:0]     req_op;

    logic [PW-1:0]  pick;
    logic [PW-1:0]  idx;
    logic           a_fire;
    logic           d_fire;
    logic [3:0]     cur_size;
    logic [2:0]     cur_op;
    logic [CW-1:0]  a_beats;
    logic [CW-1:0]  d_beats;
    logic           a_last;
    logic           d_last;
    logic [PW-1:0]  owner_next;

    // Beats of a 32-bit bus for log2(bytes)=sz, oversize requests clamped to MAX_SIZE
    function automatic logic [CW-1:0] beats_of(input logic [3:0] sz);
        logic [3:0] s_clamp;
        s_clamp = (sz > 4'(MAX_SIZE)) ? 4'(MAX_SIZE) : sz;
        return (s_clamp <= 4'd2) ? CW'(1) : (CW'(1) << (s_clamp - 4'd2));
    endfunction

    // First requester at or after rr_ptr; scanning downward lets the nearest one win
    always_comb begin
        pick = owner;
        idx  = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            idx = PW'((int'(rr_ptr) + i) % NUM_MASTERS);
            if (m.a_valid[idx]) pick = idx;
        end
    end

    always_comb begin
        m.a_ready  = '0;
        m.d_valid  = '0;
        s.a_valid  = '0;
        s.d_ready  = '0;
        if (reset) begin
            case (state)
                GRANT, A_XFER: begin
                    s.a_valid[0]     = m.a_valid[owner];
                    m.a_ready[owner] = s.a_ready[0];
                end
                D_WAIT: begin
                    m.d_valid[owner] = s.d_valid[0];
                    s.d_ready[0]     = m.d_ready[owner];
                end
                default: ;
            endcase
        end
    end

    assign s.a_bits_opcode[0]  = m.a_bits_opcode[owner];
    assign s.a_bits_param[0]   = m.a_bits_param[owner];
    assign s.a_bits_size[0]    = m.a_bits_size[owner];
    assign s.a_bits_source[0]  = m.a_bits_source[owner];
    assign s.a_bits_address[0] = m.a_bits_address[owner];
    assign s.a_bits_mask[0]    = m.a_bits_mask[owner];
    assign s.a_bits_data[0]    = m.a_bits_data[owner];

    assign m.d_bits_opcode  = s.d_bits_opcode;
    assign m.d_bits_param   = s.d_bits_param;
    assign m.d_bits_size    = s.d_bits_size;
    assign m.d_bits_source  = s.d_bits_source;
    assign m.d_bits_sink    = s.d_bits_sink;
    assign m.d_bits_addr_lo = s.d_bits_addr_lo;
    assign m.d_bits_data    = s.d_bits_data;
    assign m.d_bits_error   = s.d_bits_error;

    assign a_fire = s.a_valid[0] && s.a_ready[0];
    assign d_fire = s.d_valid[0] && s.d_ready[0];

    // The first beat is sized from the live request; later beats use the latched copy
    assign cur_size = (count == '0) ? m.a_bits_size[owner]   : req_size;
    assign cur_op   = (count == '0) ? m.a_bits_opcode[owner] : req_op;
    assign a_beats  = (cur_op == 3'd0 || cur_op == 3'd1) ? beats_of(cur_size) : CW'(1);
    assign a_last   = (count == a_beats - CW'(1));
    assign d_beats  = (s.d_bits_opcode == 3'd1) ? beats_of(req_size) : CW'(1);
    assign d_last   = (count == d_beats - CW'(1));

    assign owner_next = (owner == PW'(NUM_MASTERS - 1)) ? '0 : owner + PW'(1);
    assign busy       = reset && (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            count    <= '0;
            req_size <= '0;
            req_op   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m.a_valid) begin
                        owner <= pick;
                        state <= GRANT;
                    end
                end
                GRANT, A_XFER: begin
                    if (a_fire) begin
                        if (count == '0) begin
                            req_size <= m.a_bits_size[owner];
                            req_op   <= m.a_bits_opcode[owner];
                        end
                        if (a_last) begin
                            state <= D_WAIT;
                            count <= '0;
                        end else begin
                            state <= A_XFER;
                            count <= count + CW'(1);
                        end
                    end else begin
                        state <= A_XFER;
                    end
                end
                D_WAIT: begin
                    if (d_fire) begin
                        if (d_last) begin
                            state  <= IDLE;
                            rr_ptr <= owner_next;
                            count  <= '0;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tilelink_ul_arbiter.sv
// tb/tb_tilelink_ul_arbiter.sv - randomized self-checking bench against a transaction-level round-robin model
module tb_tilelink_ul_arbiter;
    localparam int N        = 2;
    localparam int SRC_W    = 1;
    localparam int MAX_SIZE = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic busy;

    always #5 clock = ~clock;

    tilelink_ul_arbiter_if #(.N(N), .SRC_W(SRC_W)) mif ();
    tilelink_ul_arbiter_if #(.N(1), .SRC_W(SRC_W)) sif ();

    tilelink_ul_arbiter #(.NUM_MASTERS(N), .SRC_W(SRC_W), .MAX_SIZE(MAX_SIZE)) dut (
        .clock (clock),
        .reset (reset),
        .m     (mif),
        .s     (sif),
        .busy  (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit               pend  [N];
    int               r_op  [N];
    int               r_size[N];
    logic [31:0]      r_addr[N];
    logic [31:0]      r_data[N];
    logic [SRC_W-1:0] r_src [N];
    int               bidx  [N];
    int               rr_exp = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_beats(input int sz);
        int s;
        s = (sz > MAX_SIZE) ? MAX_SIZE : sz;
        return ((1 << s) < 4) ? 1 : (1 << s) / 4;
    endfunction

    function automatic int a_beats_of(input int op, input int sz);
        return (op == 0 || op == 1) ? ref_beats(sz) : 1;
    endfunction

    function automatic int d_op_of(input int op);
        return (op == 4) ? 1 : ((op == 5) ? 2 : 0);
    endfunction

    function automatic int d_beats_of(input int op, input int sz);
        return (op == 4) ? ref_beats(sz) : 1;
    endfunction

    function automatic int pick_owner();
        for (int k = 0; k < N; k++)
            if (pend[(rr_exp + k) % N]) return (rr_exp + k) % N;
        return -1;
    endfunction

    task automatic new_req(input int mi, input int op, input int sz, input logic [31:0] addr);
        pend[mi]   = 1'b1;
        r_op[mi]   = op;
        r_size[mi] = sz;
        r_addr[mi] = addr;
        r_data[mi] = $urandom;
        r_src[mi]  = SRC_W'($urandom);
        bidx[mi]   = 0;
    endtask

    task automatic drive_masters(input int o, input bit ov);
        for (int mi = 0; mi < N; mi++) begin
            mif.a_valid[mi]        = (mi == o) ? ov : pend[mi];
            mif.a_bits_opcode[mi]  = 3'(r_op[mi]);
            mif.a_bits_param[mi]   = 3'(mi);
            mif.a_bits_size[mi]    = 4'(r_size[mi]);
            mif.a_bits_source[mi]  = r_src[mi];
            mif.a_bits_address[mi] = r_addr[mi];
            mif.a_bits_mask[mi]    = 4'hF;
            mif.a_bits_data[mi]    = r_data[mi] + 32'(bidx[mi]);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_s_a_valid"}, sif.a_valid, 0);
        check_eq({tag, "_s_d_ready"}, sif.d_ready, 0);
        check_eq({tag, "_m_a_ready"}, mif.a_ready, 0);
        check_eq({tag, "_m_d_valid"}, mif.d_valid, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    task automatic run_txn(input int abort_after, input bit fix_d, input logic [31:0] d_word);
        int o, a_left, d_left, cyc, a_fired;
        bit granted, done, ov, a_fire, d_fire;
        o = pick_owner();
        if (o < 0) begin
            check_eq("no_pending_request", 0, 1);
            return;
        end
        a_left = a_beats_of(r_op[o], r_size[o]);
        d_left = d_beats_of(r_op[o], r_size[o]);
        granted = 0; done = 0; cyc = 0; a_fired = 0;
        while (!done && cyc < 600) begin
            @(negedge clock);
            ov = granted ? ($urandom_range(0, 4) != 0) : 1'b1;
            drive_masters(o, (a_left > 0) ? ov : 1'b0);
            sif.a_ready[0]     = ($urandom_range(0, 2) != 0);
            sif.d_valid[0]     = $urandom_range(0, 1) != 0;
            sif.d_bits_opcode  = 3'(d_op_of(r_op[o]));
            sif.d_bits_param   = 2'($urandom);
            sif.d_bits_size    = 4'(r_size[o]);
            sif.d_bits_source  = r_src[o];
            sif.d_bits_sink    = 1'($urandom);
            sif.d_bits_addr_lo = 2'($urandom);
            sif.d_bits_data    = fix_d ? d_word : $urandom;
            sif.d_bits_error   = 1'b0;
            mif.d_ready        = N'($urandom);
            #1;
            for (int j = 0; j < N; j++) begin
                if (j != o) begin
                    check_eq("other_a_ready", mif.a_ready[j], 0);
                    check_eq("other_d_valid", mif.d_valid[j], 0);
                end
            end
            if (!granted) begin
                check_eq("idle_busy", busy, 0);
                check_eq("idle_s_a_valid", sif.a_valid, 0);
                check_eq("idle_a_ready", mif.a_ready[o], 0);
                check_eq("idle_s_d_ready", sif.d_ready, 0);
                check_eq("idle_d_valid", mif.d_valid[o], 0);
            end else if (a_left > 0) begin
                check_eq("a_busy", busy, 1);
                check_eq("a_s_a_valid", sif.a_valid[0], ov);
                check_eq("a_m_a_ready", mif.a_ready[o], sif.a_ready[0]);
                check_eq("a_owner_addr", sif.a_bits_address[0], r_addr[o]);
                check_eq("a_data", sif.a_bits_data[0], r_data[o] + 32'(a_fired));
                check_eq("a_source", sif.a_bits_source[0], r_src[o]);
                check_eq("a_opcode", sif.a_bits_opcode[0], r_op[o]);
                check_eq("a_s_d_ready", sif.d_ready, 0);
                check_eq("a_d_valid", mif.d_valid[o], 0);
            end else begin
                check_eq("d_busy", busy, 1);
                check_eq("d_s_a_valid", sif.a_valid, 0);
                check_eq("d_a_ready", mif.a_ready[o], 0);
                check_eq("d_m_d_valid", mif.d_valid[o], sif.d_valid[0]);
                check_eq("d_s_d_ready", sif.d_ready[0], mif.d_ready[o]);
                check_eq("d_data", mif.d_bits_data, fix_d ? d_word : sif.d_bits_data);
                check_eq("d_opcode", mif.d_bits_opcode, d_op_of(r_op[o]));
            end
            a_fire = granted && a_left > 0 && ov && sif.a_ready[0];
            d_fire = granted && a_left == 0 && sif.d_valid[0] && mif.d_ready[o];
            @(posedge clock);
            if (!granted) begin
                granted = 1;
            end else if (a_fire) begin
                a_left--;
                a_fired++;
                bidx[o]++;
                if (a_fired == abort_after) done = 1;
            end else if (d_fire) begin
                d_left--;
                if (d_left == 0) begin
                    done    = 1;
                    pend[o] = 1'b0;
                    rr_exp  = (o + 1) % N;
                end
            end
            cyc++;
        end
        check_eq("txn_timeout", done, 1);
    endtask

    task automatic hold_reset(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            reset = 1'b0;
            drive_masters(-1, 1'b0);
            sif.a_ready[0] = 1'b1;
            sif.d_valid[0] = 1'b1;
            mif.d_ready    = '1;
            #1;
            check_quiet(tag);
        end
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    initial begin
        int ops[4];
        ops = '{0, 1, 4, 5};
        for (int mi = 0; mi < N; mi++) begin
            pend[mi] = 0; r_op[mi] = 4; r_size[mi] = 2; r_addr[mi] = 0;
            r_data[mi] = 0; r_src[mi] = 0; bidx[mi] = 0;
        end
        sif.a_ready = '0; sif.d_valid = '0; mif.d_ready = '0;
        sif.d_bits_opcode = '0; sif.d_bits_param = '0; sif.d_bits_size = '0;
        sif.d_bits_source = '0; sif.d_bits_sink = '0; sif.d_bits_addr_lo = '0;
        sif.d_bits_data = '0; sif.d_bits_error = '0;

        new_req(0, 4, 2, 32'h1000_0000);
        new_req(1, 4, 2, 32'h2000_0040);
        hold_reset(3, "reset");
        rr_exp = 0;
        run_txn(-1, 1'b1, 32'hDEADBEEF);

        for (int i = 0; i < 6; i++) begin
            for (int mi = 0; mi < N; mi++)
                if (!pend[mi]) new_req(mi, 4, 2, {4'(mi + 1), 28'($urandom)});
            run_txn(-1, 1'b0, 32'h0);
        end
        while (pick_owner() >= 0) run_txn(-1, 1'b0, 32'h0);
        if (rr_exp == 0) begin
            new_req(0, 4, 2, 32'h1000_0100);
            run_txn(-1, 1'b0, 32'h0);
        end

        new_req(1, 0, 4, 32'h2000_0200);
        new_req(0, 4, 2, 32'h1000_0200);
        run_txn(-1, 1'b0, 32'h0);
        run_txn(-1, 1'b0, 32'h0);

        new_req(0, 4, 6, 32'h1000_0400);
        run_txn(-1, 1'b0, 32'h0);

        new_req(0, 4, 2, 32'h1000_0800);
        new_req(1, 0, 5, 32'h2000_0800);
        run_txn(2, 1'b0, 32'h0);
        hold_reset(2, "reset_mid");
        rr_exp  = 0;
        bidx[1] = 0;
        run_txn(-1, 1'b0, 32'h0);
        run_txn(-1, 1'b0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            for (int mi = 0; mi < N; mi++)
                if (!pend[mi] && $urandom_range(0, 2) != 0)
                    new_req(mi, ops[$urandom_range(0, 3)], $urandom_range(0, 7), {4'(mi + 1), 28'($urandom)});
            if (pick_owner() < 0) begin
                new_req(0, ops[$urandom_range(0, 3)], $urandom_range(0, 7), {4'h1, 28'($urandom)});
            end
            run_txn(-1, 1'b0, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
